atp_section_tracker: RTL and testbench
======================================

# atp_section_tracker

Parametrised successor to the fixed 12-input ATP section controller. Tracks a single train across `NUM_SECTIONS` sequential track-occupancy sensors and reports its current section index and direction. Flags out-of-sequence sensor events, overspeed (too-short section dwell) and stall (too-long dwell), and raises a brake request. Sits between the synchronised trackside sensor bank and the ATP supervisory/brake logic.

## Interface
- `NUM_SECTIONS`, 12: number of sensors/sections, minimum 2.
- `POS_W`, `$clog2(NUM_SECTIONS)`: section index width (derived).
- `MIN_DWELL`, 4: minimum legal clk cycles between advances; fewer means overspeed.
- `MAX_DWELL`, 50: dwell at which a stall fault is raised; must exceed `MIN_DWELL`.
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `sensor`  in  `NUM_SECTIONS`: occupancy sensors; bit i is section i. Already synchronous to `clk`.
- `ack_fault`  in  1: clears the fault and overspeed flags, one-cycle pulse.
- `position`  out  `POS_W`: current section index.
- `dir`  out  1: 0 = forward (ascending index), 1 = reverse.
- `valid`  out  1: a train is being tracked.
- `overspeed`  out  1: sticky overspeed flag.
- `fault`  out  1: tracker is in the FAULT state.
- `fault_code`  out  2: 0 none, 1 SKIP, 2 STALL, 3 ENTRY.
- `brake_req`  out  1: equals `fault | overspeed`.

## Operation
- Rise detect: `rise = sensor & ~sensor_q`, where `sensor_q` is the registered copy. Only rising edges drive transitions.
- States are IDLE, TRACK and FAULT.
- IDLE:
  - Rise on sensor 0 only: enter TRACK with position=0, dir=0, dwell=0.
  - With reverse enabled, rise on sensor N-1 only: enter TRACK with position=N-1, dir=1.
  - Any other rise pattern, including simultaneous entry rises: enter FAULT with code ENTRY.
- TRACK, at position p:
  - The next sensor is p+1 when dir=0 and p-1 when dir=1.
  - Rise on exactly the next sensor: position advances to it and dwell resets to 0. If dwell was below `MIN_DWELL` at that moment, set `overspeed`.
  - Rise on sensor p alone: ignored (re-trigger).
  - Rise on any other sensor, or more than one rise in the same cycle: enter FAULT with code SKIP. Position is held.
  - Dwell increments every cycle with no advance. When it reaches `MAX_DWELL-1`, enter FAULT with code STALL.
  - Exit: at the terminal section (N-1 forward, 0 reverse), a fall of that sensor returns to IDLE, with valid=0 and position/dir held.
- FAULT:
  - Position and dir are held; valid=1.
  - Leaves to IDLE only when `ack_fault`=1 and all sensors are low. Until then, `fault_code` is held.
- `ack_fault` clears `overspeed` in any state. If a new overspeed event occurs in the same cycle, set wins.

## Timing
- Reset values: position=0, dir=0, valid=0, overspeed=0, fault=0, fault_code=0, brake_req=0, state=IDLE, dwell=0, sensor_q=0. Reset applies immediately, including mid-track.
- Latency: a sensor change sampled on edge k is reflected on all outputs after edge k (one registered stage). There is no combinational path from input to output.
- The dwell counter saturates at `MAX_DWELL`, is `$clog2(MAX_DWELL+1)` bits wide, and is unsigned.
- Two rises seen on consecutive cycles are two separate events.

## Configuration
- `ATP_REVERSE_EN` defined:
  - Entry at sensor N-1 is legal, with dir=1.
  - In TRACK, a rise on p-1 while dir=0 (or p+1 while dir=1) reverses direction: dir toggles, position moves to that sensor and dwell resets.
  - Overspeed checking applies to reversals as well.
- `ATP_REVERSE_EN` undefined:
  - dir is tied to 0.
  - A rise on sensor N-1 in IDLE raises the ENTRY fault.
  - Any backward rise raises the SKIP fault.

## Structure
- Package `atp_pkg` holds:
  - the state enum (IDLE, TRACK, FAULT);
  - the fault-code enum (NONE, SKIP, STALL, ENTRY);
  - the default parameter constants.
- Sub-module `atp_dwell_timer`: a saturating counter with clear, plus `below_min` and `at_max` compare outputs.

## Test plan
All scenarios use N=12, MIN_DWELL=4, MAX_DWELL=50.
- Forward run: reset, then raise sensors 0..11 in order, 10 cycles apart and overlapping by 5 cycles. Required: position steps 0 to 11, valid=1, no flags. When sensor 11 falls, valid=0 one cycle later.
- Skip: at position 3, raise sensor 5. Required: fault=1, fault_code=1, brake_req=1, position stays 3. Then `ack_fault` with all sensors low: IDLE, fault=0.
- Overspeed: advance 2→3 two cycles after the 1→2 advance. Required: overspeed=1 and brake_req=1, position=3. `ack_fault` clears overspeed; tracking continues.
- Stall: hold position 6 with no further rise. Required: FAULT with fault_code=2 exactly 49 cycles after the advance into section 6.
- Reverse entry:
  - With `ATP_REVERSE_EN`, raise sensor 11 from IDLE: position=11, dir=1; walking down reaches 0.
  - Without it: fault_code=3.
- Async reset: assert `rst` mid-track at position 7, off a clock edge. Required: all outputs read 0 before the next clock edge.

Source files
------------

// File: rtl/atp_pkg.sv
// Shared state/fault-code types and default parameters for the ATP section tracker.
package atp_pkg;

    localparam int unsigned DefNumSections = 12;
    localparam int unsigned DefMinDwell    = 4;
    localparam int unsigned DefMaxDwell    = 50;

    typedef enum logic [1:0] {
        StIdle,
        StTrack,
        StFault
    } atp_state_e;

    typedef enum logic [1:0] {
        FcNone  = 2'd0,
        FcSkip  = 2'd1,
        FcStall = 2'd2,
        FcEntry = 2'd3
    } atp_fault_e;

endpackage

// File: rtl/atp_dwell_timer.sv
// Saturating section-dwell counter with synchronous clear and min/max compare flags.
module atp_dwell_timer
    import atp_pkg::*;
#(
    parameter int unsigned MIN_DWELL = DefMinDwell,
    parameter int unsigned MAX_DWELL = DefMaxDwell
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic below_min,
    output logic at_max
);

    localparam int unsigned CntW = $clog2(MAX_DWELL + 1);

    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != CntW'(MAX_DWELL))) begin
            count_d = count_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign below_min = (count_q < CntW'(MIN_DWELL));
    // Asserted on the cycle whose increment brings the count to MAX_DWELL-1.
    assign at_max    = (count_q >= CntW'(MAX_DWELL - 2));

endmodule

// File: rtl/atp_section_tracker.sv
// Single-train section tracker with skip/stall/entry faults and overspeed detection.
// Define ATP_REVERSE_EN to allow reverse-direction entry and in-track reversals.
module atp_section_tracker
    import atp_pkg::*;
#(
    parameter int unsigned NUM_SECTIONS = DefNumSections,
    parameter int unsigned POS_W        = $clog2(NUM_SECTIONS),
    parameter int unsigned MIN_DWELL    = DefMinDwell,
    parameter int unsigned MAX_DWELL    = DefMaxDwell
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_SECTIONS-1:0] sensor,
    input  logic                    ack_fault,
    output logic [POS_W-1:0]        position,
    output logic                    dir,
    output logic                    valid,
    output logic                    overspeed,
    output logic                    fault,
    output logic [1:0]              fault_code,
    output logic                    brake_req
);

    localparam logic [NUM_SECTIONS-1:0] OneHot0 = {{(NUM_SECTIONS - 1){1'b0}}, 1'b1};
    localparam logic [POS_W-1:0]        LastPos = POS_W'(NUM_SECTIONS - 1);

    atp_state_e              state_q, state_d;
    atp_fault_e              code_q, code_d;
    logic [POS_W-1:0]        pos_q, pos_d;
    logic                    dir_q, dir_d;
    logic                    ovs_q, ovs_d;
    logic [NUM_SECTIONS-1:0] sensor_q, rise, fall;

    logic                    fwd_ok, bwd_ok, next_ok, at_term;
    logic [POS_W-1:0]        next_pos;
    logic [NUM_SECTIONS-1:0] here_mask, next_mask;
    logic                    dwell_clr, dwell_inc, below_min, at_max;

    assign rise = sensor & ~sensor_q;
    assign fall = ~sensor & sensor_q;

    // Neighbour existence in each direction; "next" follows the current travel direction.
    assign fwd_ok    = (pos_q != LastPos);
    assign bwd_ok    = (pos_q != '0);
    assign next_ok   = dir_q ? bwd_ok : fwd_ok;
    assign next_pos  = dir_q ? (pos_q - POS_W'(1)) : (pos_q + POS_W'(1));
    assign at_term   = !next_ok;
    assign here_mask = OneHot0 << pos_q;
    assign next_mask = OneHot0 << next_pos;

`ifdef ATP_REVERSE_EN
    localparam logic [NUM_SECTIONS-1:0] LastMask = OneHot0 << LastPos;

    logic                    back_ok;
    logic [POS_W-1:0]        back_pos;
    logic [NUM_SECTIONS-1:0] back_mask;

    assign back_ok   = dir_q ? fwd_ok : bwd_ok;
    assign back_pos  = dir_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
    assign back_mask = OneHot0 << back_pos;
`endif

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        dir_d     = dir_q;
        code_d    = code_q;
        ovs_d     = ovs_q & ~ack_fault;
        dwell_clr = 1'b1;
        dwell_inc = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rise == OneHot0) begin
                    state_d = StTrack;
                    pos_d   = '0;
                    dir_d   = 1'b0;
                end
`ifdef ATP_REVERSE_EN
                else if (rise == LastMask) begin
                    state_d = StTrack;
                    pos_d   = LastPos;
                    dir_d   = 1'b1;
                end
`endif
                else if (rise != '0) begin
                    state_d = StFault;
                    code_d  = FcEntry;
                end
            end
            StTrack: begin
                dwell_clr = 1'b0;
                dwell_inc = 1'b1;
                if ((rise == '0) || (rise == here_mask)) begin
                    if (at_term && ((fall & here_mask) != '0)) begin
                        state_d = StIdle;
                    end else if (at_max) begin
                        state_d = StFault;
                        code_d  = FcStall;
                    end
                end else if (next_ok && (rise == next_mask)) begin
                    pos_d     = next_pos;
                    dwell_clr = 1'b1;
                    if (below_min) ovs_d = 1'b1;
                end
`ifdef ATP_REVERSE_EN
                else if (back_ok && (rise == back_mask)) begin
                    pos_d     = back_pos;
                    dir_d     = ~dir_q;
                    dwell_clr = 1'b1;
                    if (below_min) ovs_d = 1'b1;
                end
`endif
                else begin
                    state_d = StFault;
                    code_d  = FcSkip;
                end
            end
            StFault: begin
                if (ack_fault && (sensor == '0)) begin
                    state_d = StIdle;
                    code_d  = FcNone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            code_q   <= FcNone;
            pos_q    <= '0;
            dir_q    <= 1'b0;
            ovs_q    <= 1'b0;
            sensor_q <= '0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            ovs_q    <= ovs_d;
            sensor_q <= sensor;
        end
    end

    atp_dwell_timer #(
        .MIN_DWELL(MIN_DWELL),
        .MAX_DWELL(MAX_DWELL)
    ) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .clr      (dwell_clr),
        .inc      (dwell_inc),
        .below_min(below_min),
        .at_max   (at_max)
    );

    assign position   = pos_q;
    assign dir        = dir_q;
    assign valid      = (state_q != StIdle);
    assign fault      = (state_q == StFault);
    assign fault_code = code_q;
    assign overspeed  = ovs_q;
    assign brake_req  = fault | ovs_q;

endmodule

// File: tb/tb_atp_section_tracker.sv
// Scoreboard bench: stimulus queues expected snapshots per cycle, a negedge monitor compares.
module tb_atp_section_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] sensor;
    logic        ack_fault;
    logic [3:0]  position;
    logic        dir, valid, overspeed, fault, brake_req;
    logic [1:0]  fault_code;

    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    typedef struct packed {
        logic [3:0] pos;
        logic       dir;
        logic       valid;
        logic       ovs;
        logic       fault;
        logic [1:0] code;
        logic       brake;
    } obs_t;

    typedef struct {
        int unsigned when;
        obs_t        exp;
        string       name;
    } item_t;

    item_t sb[$];

    atp_section_tracker #(
        .NUM_SECTIONS(12),
        .MIN_DWELL   (4),
        .MAX_DWELL   (50)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sensor    (sensor),
        .ack_fault (ack_fault),
        .position  (position),
        .dir       (dir),
        .valid     (valid),
        .overspeed (overspeed),
        .fault     (fault),
        .fault_code(fault_code),
        .brake_req (brake_req)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t mk(input int p, input bit d, input bit v, input bit o, input bit f,
                                input int c);
        obs_t m;
        m.pos   = 4'(p);
        m.dir   = d;
        m.valid = v;
        m.ovs   = o;
        m.fault = f;
        m.code  = 2'(c);
        m.brake = f | o;
        return m;
    endfunction

    task automatic push(input int unsigned d, input obs_t e, input string nm);
        item_t it;
        int    idx;
        it.when = cyc + d;
        it.exp  = e;
        it.name = nm;
        idx = sb.size();
        while (idx > 0 && sb[idx-1].when > it.when) idx--;
        sb.insert(idx, it);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step(input int idx, input int gap, input obs_t e, input string nm);
        sensor      = '0;
        sensor[idx] = 1'b1;
        push(1, e, nm);
        tick(gap);
    endtask

    // Monitor: compare every snapshot whose cycle has arrived.
    always @(negedge clk) begin
        obs_t  act;
        item_t cur;
        act.pos   = position;
        act.dir   = dir;
        act.valid = valid;
        act.ovs   = overspeed;
        act.fault = fault;
        act.code  = fault_code;
        act.brake = brake_req;
        while (sb.size() > 0 && sb[0].when <= cyc) begin
            cur = sb.pop_front();
            checks++;
            if (cur.when != cyc || act !== cur.exp) begin
                failures++;
                $display("FAIL %s @cyc %0d: got pos=%0d dir=%0b valid=%0b ovs=%0b fault=%0b code=%0d brake=%0b, want pos=%0d dir=%0b valid=%0b ovs=%0b fault=%0b code=%0d brake=%0b",
                         cur.name, cyc, act.pos, act.dir, act.valid, act.ovs, act.fault,
                         act.code, act.brake, cur.exp.pos, cur.exp.dir, cur.exp.valid,
                         cur.exp.ovs, cur.exp.fault, cur.exp.code, cur.exp.brake);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        sensor    = '0;
        ack_fault = 1'b0;
        #23 rst   = 1'b0;
        tick(1);
        push(0, mk(0, 0, 0, 0, 0, 0), "reset_idle");
        tick(2);

        // Forward run: sensor i high for cycles [10i, 10i+15).
        for (int t = 0; t <= 128; t++) begin
            for (int i = 0; i < 12; i++) sensor[i] = (t >= 10 * i) && (t < 10 * i + 15);
            if (t % 10 == 0 && t / 10 < 12) push(1, mk(t / 10, 0, 1, 0, 0, 0), "fwd_step");
            if (t == 125) push(1, mk(11, 0, 0, 0, 0, 0), "fwd_exit");
            tick(1);
        end
        sensor = '0;
        tick(2);

        // Skip: at position 3 raise sensor 5.
        for (int i = 0; i <= 3; i++) step(i, 6, mk(i, 0, 1, 0, 0, 0), "skip_walk");
        sensor[5] = 1'b1;
        push(1, mk(3, 0, 1, 0, 1, 1), "skip_fault");
        tick(3);
        push(0, mk(3, 0, 1, 0, 1, 1), "skip_hold");
        ack_fault = 1'b1;
        push(1, mk(3, 0, 1, 0, 1, 1), "skip_ack_busy");
        tick(1);
        ack_fault = 1'b0;
        sensor    = '0;
        tick(1);
        ack_fault = 1'b1;
        push(1, mk(3, 0, 0, 0, 0, 0), "skip_clear");
        tick(1);
        ack_fault = 1'b0;
        tick(2);

        // Overspeed: 2->3 advance two cycles after 1->2.
        step(0, 6, mk(0, 0, 1, 0, 0, 0), "ovs_walk");
        step(1, 6, mk(1, 0, 1, 0, 0, 0), "ovs_walk");
        step(2, 2, mk(2, 0, 1, 0, 0, 0), "ovs_walk");
        step(3, 1, mk(3, 0, 1, 1, 0, 0), "ovs_set");
        ack_fault = 1'b1;
        push(1, mk(3, 0, 1, 0, 0, 0), "ovs_clear");
        tick(1);
        ack_fault = 1'b0;
        tick(4);
        step(4, 6, mk(4, 0, 1, 0, 0, 0), "ovs_continue");

        // Stall: enter section 6 and hold.
        step(5, 6, mk(5, 0, 1, 0, 0, 0), "stall_walk");
        sensor    = '0;
        sensor[6] = 1'b1;
        push(1, mk(6, 0, 1, 0, 0, 0), "stall_enter");
        push(49, mk(6, 0, 1, 0, 0, 0), "stall_pre");
        push(50, mk(6, 0, 1, 0, 1, 2), "stall_fault");
        tick(55);
        sensor    = '0;
        ack_fault = 1'b1;
        push(1, mk(6, 0, 0, 0, 0, 0), "stall_clear");
        tick(1);
        ack_fault = 1'b0;
        tick(2);

        // Reverse entry from IDLE at sensor 11.
`ifdef ATP_REVERSE_EN
        step(11, 6, mk(11, 1, 1, 0, 0, 0), "rev_entry");
        for (int i = 10; i >= 0; i--) step(i, 6, mk(i, 1, 1, 0, 0, 0), "rev_walk");
        sensor = '0;
        push(1, mk(0, 1, 0, 0, 0, 0), "rev_exit");
        tick(2);
`else
        step(11, 2, mk(6, 0, 1, 0, 1, 3), "entry_fault");
        sensor    = '0;
        ack_fault = 1'b1;
        push(1, mk(6, 0, 0, 0, 0, 0), "entry_clear");
        tick(1);
        ack_fault = 1'b0;
        tick(2);
`endif

        // Backward rise in TRACK: reversal when enabled, SKIP otherwise.
        step(0, 6, mk(0, 0, 1, 0, 0, 0), "back_walk");
        step(1, 6, mk(1, 0, 1, 0, 0, 0), "back_walk");
        step(2, 6, mk(2, 0, 1, 0, 0, 0), "back_walk");
`ifdef ATP_REVERSE_EN
        step(1, 6, mk(1, 1, 1, 0, 0, 0), "back_reverse");
        step(0, 6, mk(0, 1, 1, 0, 0, 0), "back_rev_walk");
        sensor = '0;
        push(1, mk(0, 1, 0, 0, 0, 0), "back_rev_exit");
        tick(2);
`else
        step(1, 2, mk(2, 0, 1, 0, 1, 1), "back_skip");
        sensor    = '0;
        ack_fault = 1'b1;
        push(1, mk(2, 0, 0, 0, 0, 0), "back_clear");
        tick(1);
        ack_fault = 1'b0;
        tick(2);
`endif

        // Async reset mid-track at position 7, asserted between clock edges.
        for (int i = 0; i <= 7; i++) step(i, 6, mk(i, 0, 1, 0, 0, 0), "arst_walk");
        #1 rst = 1'b1;
        push(0, mk(0, 0, 0, 0, 0, 0), "async_reset");
        tick(2);
        #2 rst = 1'b0;
        sensor = '0;
        tick(1);
        push(0, mk(0, 0, 0, 0, 0, 0), "post_reset");
        tick(3);

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
